// File: rtl/tych_pkg.sv
// rtl/tych_pkg.sv - shared beat type for the TX path
package tych_pkg;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic         valid;
    logic         error;
    logic         skip_crc;
  } mac_avltx_t;

endpackage

// File: rtl/tych_tx_buf.sv
// rtl/tych_tx_buf.sv - TX beat FIFO between tych_core and MAC 0
// Registered-output FIFO with input framing check, orphan drop and counters.
module tych_tx_buf
  import tych_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  mac_avltx_t               in_tx,
  output logic                     in_ready,
  output mac_avltx_t               out_tx,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic [31:0]              pkt_count,
  output logic [15:0]              frame_err_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef struct packed {
    logic [511:0] data;
    logic         sop;
    logic         eop;
    logic         error;
    logic         skip_crc;
  } entry_t;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_IN_PKT = 1'b1
  } state_e;

  entry_t          mem_q [DEPTH];
  entry_t          wr_entry;
  entry_t          head;
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [31:0]     pkt_cnt_q, pkt_cnt_d;
  logic [15:0]     err_cnt_q, err_cnt_d;
  state_e          state_q, state_d;

  logic            push_hs;
  logic            orphan;
  logic            sop_in_pkt;
  logic            store;
  logic            pop;

  assign in_ready   = rst && (level_q < LW'(DEPTH));
  assign push_hs    = in_tx.valid && in_ready;
  assign orphan     = push_hs && (state_q == ST_IDLE) && !in_tx.sop;
  assign sop_in_pkt = push_hs && (state_q == ST_IN_PKT) && in_tx.sop;
  assign store      = push_hs && !orphan;
  assign pop        = (level_q != '0) && out_ready;

  assign head = mem_q[rd_ptr_q];

  always_comb begin
    wr_entry          = '0;
    wr_entry.data     = in_tx.data;
    wr_entry.sop      = in_tx.sop;
    wr_entry.eop      = in_tx.eop;
    wr_entry.skip_crc = in_tx.skip_crc;
    // A new sop inside an open packet marks the truncated frame as bad.
    wr_entry.error    = in_tx.error || sop_in_pkt;
  end

  // Framing FSM: only accepted (non-orphan) beats move it.
  always_comb begin
    state_d = state_q;
    if (store) begin
      state_d = in_tx.eop ? ST_IDLE : ST_IN_PKT;
    end
  end

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    level_d   = level_q;
    pkt_cnt_d = pkt_cnt_q;
    err_cnt_d = err_cnt_q;
    if (store) begin
      wr_ptr_d = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    case ({store, pop})
      2'b10:   level_d = level_q + LW'(1);
      2'b01:   level_d = level_q - LW'(1);
      default: level_d = level_q;
    endcase
    if (pop && head.eop && (pkt_cnt_q != '1)) begin
      pkt_cnt_d = pkt_cnt_q + 32'd1;
    end
    if ((orphan || sop_in_pkt) && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      pkt_cnt_q <= '0;
      err_cnt_q <= '0;
      state_q   <= ST_IDLE;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      pkt_cnt_q <= pkt_cnt_d;
      err_cnt_q <= err_cnt_d;
      state_q   <= state_d;
    end
  end

  // Storage is left unreset; level gates everything read from it.
  always_ff @(posedge clk) begin
    if (store) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

  always_comb begin
    out_tx = '0;
    if (level_q != '0) begin
      out_tx.valid    = 1'b1;
      out_tx.data     = head.data;
      out_tx.sop      = head.sop;
      out_tx.eop      = head.eop;
      out_tx.error    = head.error;
      out_tx.skip_crc = head.skip_crc;
    end
  end

  assign level           = level_q;
  assign pkt_count       = pkt_cnt_q;
  assign frame_err_count = err_cnt_q;

endmodule

// File: tb/tb_tych_tx_buf.sv
// tb/tb_tych_tx_buf.sv - randomized self-checking bench for tych_tx_buf
module tb_tych_tx_buf;
  import tych_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  mac_avltx_t  in_tx;
  logic        in_ready;
  mac_avltx_t  out_tx;
  logic        out_ready;
  logic [2:0]  level;
  logic [31:0] pkt_count;
  logic [15:0] frame_err_count;

  tych_tx_buf #(.DEPTH(DEPTH)) dut (
    .clk             (clk),
    .rst             (rst),
    .in_tx           (in_tx),
    .in_ready        (in_ready),
    .out_tx          (out_tx),
    .out_ready       (out_ready),
    .level           (level),
    .pkt_count       (pkt_count),
    .frame_err_count (frame_err_count)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference: a queue of beats the MAC should see, a packet-open flag, counters.
  mac_avltx_t  mq[$];
  bit          m_in_pkt;
  logic [31:0] m_pkt;
  logic [15:0] m_err;

  task automatic check_eq(input string tag, input logic [575:0] obs, input logic [575:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    mac_avltx_t e;
    e = '0;
    if (mq.size() > 0) e = mq[0];
    check_eq("out_tx", out_tx, e);
    check_eq("level", level, mq.size());
    check_eq("in_ready", in_ready, (rst && mq.size() < DEPTH));
    check_eq("pkt_count", pkt_count, m_pkt);
    check_eq("frame_err_count", frame_err_count, m_err);
  endtask

  function automatic logic [511:0] rand_data();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  // Called at a negedge: apply inputs, advance the model across the next posedge, check.
  task automatic drive(input bit vld, input bit sop, input bit eop, input bit err,
                       input bit skip, input logic [511:0] d, input bit ordy,
                       output bit pushed);
    mac_avltx_t b;
    bit can_push, do_pop;
    in_tx = '{data: d, sop: sop, eop: eop, valid: vld, error: err, skip_crc: skip};
    out_ready = ordy;
    can_push = rst && vld && (mq.size() < DEPTH);
    do_pop   = rst && (mq.size() > 0) && ordy;
    if (do_pop) begin
      b = mq.pop_front();
      if (b.eop && m_pkt != 32'hFFFF_FFFF) m_pkt++;
    end
    if (can_push) begin
      if (!m_in_pkt && !sop) begin
        if (m_err != 16'hFFFF) m_err++;
      end else begin
        b = in_tx;
        if (m_in_pkt && sop) begin
          b.error = 1'b1;
          if (m_err != 16'hFFFF) m_err++;
        end
        mq.push_back(b);
        m_in_pkt = !eop;
      end
    end
    pushed = can_push;
    @(posedge clk);
    @(negedge clk);
    check_model();
  endtask

  task automatic idle(input bit ordy);
    bit p;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, '0, ordy, p);
  endtask

  task automatic beat(input bit sop, input bit eop, input bit ordy, output bit pushed);
    drive(1'b1, sop, eop, 1'b0, $urandom_range(0, 1), rand_data(), ordy, pushed);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    mq.delete();
    m_in_pkt = 1'b0;
    m_pkt = '0;
    m_err = '0;
    #1;
    check_model();
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_model();
  endtask

  initial begin
    bit p;
    bit have_beat, first;
    int rem, accepted, cycles;
    bit c_sop, c_eop, c_err, c_skip;
    logic [511:0] c_data;

    in_tx = '0;
    out_ready = 1'b0;
    @(negedge clk);
    @(negedge clk);
    do_reset();

    // Three-beat packet streams straight through with one cycle of latency.
    beat(1'b1, 1'b0, 1'b1, p);
    beat(1'b0, 1'b0, 1'b1, p);
    beat(1'b0, 1'b1, 1'b1, p);
    idle(1'b1);
    check_eq("r31_pkt", pkt_count, 32'd1);
    check_eq("r31_level", level, 3'd0);

    // Fill with MAC stalled, fifth beat refused, then a single pop.
    do_reset();
    beat(1'b1, 1'b0, 1'b0, p);
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 1'b0, p);
    beat(1'b0, 1'b1, 1'b0, p);
    check_eq("r32_refused", p, 1'b0);
    check_eq("r32_full", level, 3'd4);
    check_eq("r32_in_ready", in_ready, 1'b0);
    idle(1'b1);
    check_eq("r32_one_pop", level, 3'd3);
    check_eq("r32_in_ready_back", in_ready, 1'b1);
    beat(1'b0, 1'b1, 1'b1, p);
    for (int i = 0; i < 5; i++) idle(1'b1);

    // Orphan in IDLE is swallowed.
    do_reset();
    beat(1'b0, 1'b1, 1'b1, p);
    check_eq("r33_level", level, 3'd0);
    check_eq("r33_valid", out_tx.valid, 1'b0);
    check_eq("r33_err", frame_err_count, 16'd1);

    // sop inside an open packet is stored flagged.
    do_reset();
    beat(1'b1, 1'b0, 1'b1, p);
    beat(1'b1, 1'b1, 1'b1, p);
    check_eq("r34_head_error", out_tx.error, 1'b1);
    check_eq("r34_head_eop", out_tx.eop, 1'b1);
    idle(1'b1);
    check_eq("r34_err", frame_err_count, 16'd1);
    check_eq("r34_pkt", pkt_count, 32'd1);

    // Reset with a full buffer and a beat on the input.
    beat(1'b1, 1'b0, 1'b0, p);
    for (int i = 0; i < 3; i++) beat(1'b0, 1'b0, 1'b0, p);
    check_eq("r35_full", level, 3'd4);
    in_tx.valid = 1'b1;
    do_reset();
    check_eq("r35_level", level, 3'd0);
    check_eq("r35_out", out_tx, '0);
    check_eq("r35_pkt", pkt_count, 32'd0);
    check_eq("r35_in_ready", in_ready, 1'b1);
    beat(1'b0, 1'b0, 1'b0, p);
    check_eq("r35_orphan_level", level, 3'd0);
    check_eq("r35_orphan_err", frame_err_count, 16'd1);

    // Random legal framing, random valid and backpressure.
    do_reset();
    have_beat = 1'b0;
    rem = 0;
    first = 1'b0;
    accepted = 0;
    cycles = 0;
    while (accepted < 10000 && cycles < 60000) begin
      if (!have_beat) begin
        if (rem == 0) begin
          rem = $urandom_range(1, 5);
          first = 1'b1;
        end
        c_sop  = first;
        c_eop  = (rem == 1);
        c_err  = ($urandom_range(0, 7) == 0);
        c_skip = $urandom_range(0, 1);
        c_data = rand_data();
        have_beat = 1'b1;
      end
      drive($urandom_range(0, 3) != 0, c_sop, c_eop, c_err, c_skip, c_data,
            $urandom_range(0, 3) != 0, p);
      cycles++;
      if (p) begin
        have_beat = 1'b0;
        rem--;
        first = 1'b0;
        accepted++;
      end
    end
    check_eq("rand_beats_accepted", accepted, 10000);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check_eq("rand_drained", level, 3'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
